fix_session_mgr: RTL and testbench
==================================

FIX_SESSION_MGR -- requirements
Module: fix_session_mgr

Interface
REQ-001 The block SHALL have parameter NUM_HOSTS, default 4, meaning the number of independent host sessions (2..16).
REQ-002 The block SHALL have parameter HOST_W, default $clog2(NUM_HOSTS), meaning the width of the host index.
REQ-003 The block SHALL have parameter CONN_TIMEOUT, default 64, meaning the maximum cycles to wait for a TOE connect acknowledge.
REQ-004 The block SHALL have parameter HB_INTERVAL, default 256, meaning the idle cycles before a heartbeat is requested.
REQ-005 The block SHALL have parameter RX_TIMEOUT, default 640, meaning the receive-silence cycles before a session is dropped.
REQ-006 The block SHALL have the following ports:
- clk  in  1  clock; one clock, all logic rising-edge.
- rst  in  1  reset; asynchronous, active-high.
- connect_i  in  1  app connect command.
- connect_to_host_i  in  HOST_W  target of connect_i.
- disconnect_i  in  1  app disconnect command.
- disconnect_host_i  in  HOST_W  target of disconnect_i.
- connected_i  in  1  TOE connect acknowledge.
- connected_host_addr_i  in  HOST_W  host of connected_i.
- valid_i  in  1  TOE receive byte strobe.
- rx_host_i  in  HOST_W  host owning the valid_i byte.
- hb_ready_i  in  1  fifo accepts heartbeat request.
- connect_req_o  out  1  connect request pulse to fifo.
- connect_addr_o  out  HOST_W  host of connect_req_o.
- disconnect_o  out  1  disconnect pulse to fifo.
- disconnect_host_num_o  out  HOST_W  host of disconnect_o.
- hb_valid_o  out  1  heartbeat request.
- hb_host_o  out  HOST_W  host of hb_valid_o.
- session_up_o  out  NUM_HOSTS  per-host CONNECTED flag.
- timeout_o  out  1  connect-timeout pulse.
- cmd_err_o  out  1  illegal command pulse.

Function
REQ-007 The block SHALL keep one FSM per host with states IDLE, WAIT_ACK and CONNECTED, plus a per-host timer of width covering max(CONN_TIMEOUT, RX_TIMEOUT).
REQ-008 connect_i to a host in IDLE SHALL move that host to WAIT_ACK, clear its timer, and drive connect_req_o=1 and connect_addr_o=host on the next cycle for exactly one cycle.
REQ-009 connect_i to a host not in IDLE, or with connect_to_host_i >= NUM_HOSTS, SHALL be ignored and SHALL pulse cmd_err_o the next cycle.
REQ-010 In WAIT_ACK, connected_i with a matching connected_host_addr_i SHALL move the host to CONNECTED; session_up_o[host] SHALL go to 1 on the next cycle.
REQ-011 In WAIT_ACK, timer reaching CONN_TIMEOUT-1 without an acknowledge SHALL move the host to IDLE and pulse timeout_o one cycle; an acknowledge in that same cycle SHALL win.
REQ-012 connected_i for a host not in WAIT_ACK SHALL be ignored silently.
REQ-013 disconnect_i to a host in WAIT_ACK or CONNECTED SHALL move it to IDLE and pulse disconnect_o with disconnect_host_num_o=host next cycle; to an IDLE or out-of-range host it SHALL pulse cmd_err_o instead.
REQ-014 connect_i and disconnect_i in the same cycle SHALL both be processed independently; when both target the same host, the disconnect SHALL be evaluated first, so the connect sees non-IDLE state and errors.
REQ-015 In CONNECTED, valid_i with rx_host_i==host SHALL clear the rx-silence timer; reaching RX_TIMEOUT-1 SHALL flag an auto-drop for that host.
REQ-016 An auto-drop SHALL use disconnect_o only in a cycle with no app disconnect; among pending drops, the lowest index SHALL go first; others SHALL stay pending, and the dropped host SHALL go IDLE when its pulse issues.
REQ-017 In CONNECTED, a separate tx counter reaching HB_INTERVAL-1 SHALL set that host's heartbeat-pending flag, and the counter SHALL then saturate.
REQ-018 hb_valid_o/hb_host_o SHALL present one pending host chosen round-robin, starting after the last granted host.
REQ-019 hb_valid_o/hb_host_o SHALL hold stable until hb_ready_i=1.
REQ-020 On a heartbeat grant (hb_valid_o & hb_ready_i), the block SHALL clear that host's pending flag and tx counter.
REQ-021 A host leaving CONNECTED SHALL drop its heartbeat-pending flag; if it is currently presented, hb_valid_o SHALL deassert next cycle without a grant.
REQ-022 All outputs SHALL be registered, with 1-cycle command-to-output latency.

Reset
REQ-023 rst=1 SHALL asynchronously force every host to IDLE and clear all timers, pending flags and the round-robin pointer to 0.
REQ-024 rst=1 SHALL drive every output to 0.
REQ-025 Reset mid-handshake SHALL discard all state; no pulse SHALL be emitted on release.

Verification (NUM_HOSTS=4, CONN_TIMEOUT=8, HB_INTERVAL=16, RX_TIMEOUT=40)
REQ-026 connect_i host 2, then connected_i addr 2 three cycles later -> connect_req_o=1 with addr 2 for one cycle, then session_up_o=4'b0100.
REQ-027 connect_i host 1, no acknowledge -> timeout_o pulse 8 cycles after the request, then session_up_o[1]=0; a repeated connect to host 1 is accepted.
REQ-028 Hosts 0 and 3 connected, no traffic, hb_ready_i=0 -> hb_valid_o holds host 0; when hb_ready_i=1, host 0 is granted and then host 3.
REQ-029 Hosts 0 and 1 connected, silent 40 cycles, plus app disconnect host 2 (WAIT_ACK) in the expiry cycle -> disconnect_o hosts 2, 0, 1 on consecutive cycles.
REQ-030 connect_i host 0 while CONNECTED, plus disconnect_i host 3 while IDLE -> cmd_err_o pulses each, with no state change.
REQ-031 rst asserted during WAIT_ACK of host 1 -> all outputs 0 immediately; no timeout_o after release.

Source files
------------

// File: rtl/fix_session_mgr.sv
// rtl/fix_session_mgr.sv - per-host FIX session connect, heartbeat and timeout manager
module fix_session_mgr #(
  parameter int NUM_HOSTS    = 4,
  parameter int HOST_W       = $clog2(NUM_HOSTS),
  parameter int CONN_TIMEOUT = 64,
  parameter int HB_INTERVAL  = 256,
  parameter int RX_TIMEOUT   = 640
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 connect_i,
  input  logic [HOST_W-1:0]    connect_to_host_i,
  input  logic                 disconnect_i,
  input  logic [HOST_W-1:0]    disconnect_host_i,
  input  logic                 connected_i,
  input  logic [HOST_W-1:0]    connected_host_addr_i,
  input  logic                 valid_i,
  input  logic [HOST_W-1:0]    rx_host_i,
  input  logic                 hb_ready_i,
  output logic                 connect_req_o,
  output logic [HOST_W-1:0]    connect_addr_o,
  output logic                 disconnect_o,
  output logic [HOST_W-1:0]    disconnect_host_num_o,
  output logic                 hb_valid_o,
  output logic [HOST_W-1:0]    hb_host_o,
  output logic [NUM_HOSTS-1:0] session_up_o,
  output logic                 timeout_o,
  output logic                 cmd_err_o
);

  localparam int MAX_T = (CONN_TIMEOUT > RX_TIMEOUT) ? CONN_TIMEOUT : RX_TIMEOUT;
  localparam int TMR_W = $clog2(MAX_T + 1);
  localparam int TX_W  = $clog2(HB_INTERVAL + 1);
  localparam logic [TMR_W-1:0]  CONN_LAST  = TMR_W'(CONN_TIMEOUT - 1);
  localparam logic [TMR_W-1:0]  RX_LAST    = TMR_W'(RX_TIMEOUT - 1);
  localparam logic [TX_W-1:0]   HB_LAST    = TX_W'(HB_INTERVAL - 1);
  localparam logic [HOST_W:0]   HOST_LIMIT = (HOST_W + 1)'(NUM_HOSTS);
  localparam logic [HOST_W-1:0] HOST_TOP   = HOST_W'(NUM_HOSTS - 1);

  typedef enum logic [1:0] {IDLE, WAIT_ACK, CONNECTED} state_t;

  // One timer per host: connect-ack wait in WAIT_ACK, rx silence in CONNECTED
  state_t               state  [NUM_HOSTS];
  logic [TMR_W-1:0]     tmr    [NUM_HOSTS];
  logic [TX_W-1:0]      tx_cnt [NUM_HOSTS];
  logic [NUM_HOSTS-1:0] hb_pend;
  logic [NUM_HOSTS-1:0] drop_pend;
  logic [HOST_W-1:0]    rr_ptr;

  logic                 conn_ok, conn_err, dis_ok, dis_err;
  logic                 hb_grant, drop_fire, hb_v_nxt;
  logic [HOST_W-1:0]    drop_sel, ptr_nxt, hb_h_nxt, cand;
  logic [NUM_HOSTS-1:0] ack_h, dis_h, rx_hit, gnt_h, leave;
  logic [NUM_HOSTS-1:0] wait_exp, rx_exp, drop_now, pend_nxt;
  int                   s;

  // Decode commands, arbitrate auto-drops and choose the next heartbeat host
  always_comb begin
    conn_ok  = connect_i && ({1'b0, connect_to_host_i} < HOST_LIMIT)
               && (state[connect_to_host_i] == IDLE);
    conn_err = connect_i && !conn_ok;
    dis_ok   = disconnect_i && ({1'b0, disconnect_host_i} < HOST_LIMIT)
               && (state[disconnect_host_i] != IDLE);
    dis_err  = disconnect_i && !dis_ok;
    hb_grant = hb_valid_o && hb_ready_i;

    for (int h = 0; h < NUM_HOSTS; h++) begin
      ack_h[h]    = connected_i && (connected_host_addr_i == HOST_W'(h));
      dis_h[h]    = dis_ok && (disconnect_host_i == HOST_W'(h));
      rx_hit[h]   = valid_i && (rx_host_i == HOST_W'(h));
      gnt_h[h]    = hb_grant && (hb_host_o == HOST_W'(h));
      rx_exp[h]   = (state[h] == CONNECTED) && (tmr[h] == RX_LAST);
      drop_now[h] = (state[h] == CONNECTED) && (drop_pend[h] || rx_exp[h]);
      wait_exp[h] = (state[h] == WAIT_ACK) && (tmr[h] == CONN_LAST) && !ack_h[h] && !dis_h[h];
    end

    // Lowest-index drop wins, and only when the app is not using disconnect_o
    drop_sel = '0;
    for (int h = NUM_HOSTS - 1; h >= 0; h--) begin
      if (drop_now[h]) drop_sel = HOST_W'(h);
    end
    drop_fire = (|drop_now) && !dis_ok;

    for (int h = 0; h < NUM_HOSTS; h++) begin
      leave[h]    = dis_h[h] || (drop_fire && (drop_sel == HOST_W'(h)));
      pend_nxt[h] = (state[h] == CONNECTED) && !leave[h] && !gnt_h[h]
                    && (hb_pend[h] || (tx_cnt[h] == HB_LAST));
    end

    // Round-robin search starts just after the last granted host
    ptr_nxt = rr_ptr;
    if (hb_grant) ptr_nxt = (hb_host_o == HOST_TOP) ? '0 : hb_host_o + 1'b1;

    hb_v_nxt = 1'b0;
    hb_h_nxt = '0;
    cand     = '0;
    s        = 0;
    if (hb_valid_o && !hb_grant && pend_nxt[hb_host_o]) begin
      hb_v_nxt = 1'b1;
      hb_h_nxt = hb_host_o;
    end else begin
      for (int i = 0; i < NUM_HOSTS; i++) begin
        s = int'(ptr_nxt) + i;
        if (s >= NUM_HOSTS) s = s - NUM_HOSTS;
        cand = HOST_W'(s);
        if (!hb_v_nxt && pend_nxt[cand]) begin
          hb_v_nxt = 1'b1;
          hb_h_nxt = cand;
        end
      end
    end
  end

  // Per-host session FSMs, timers and all registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int h = 0; h < NUM_HOSTS; h++) begin
        state[h]  <= IDLE;
        tmr[h]    <= '0;
        tx_cnt[h] <= '0;
      end
      hb_pend               <= '0;
      drop_pend             <= '0;
      rr_ptr                <= '0;
      connect_req_o         <= 1'b0;
      connect_addr_o        <= '0;
      disconnect_o          <= 1'b0;
      disconnect_host_num_o <= '0;
      hb_valid_o            <= 1'b0;
      hb_host_o             <= '0;
      session_up_o          <= '0;
      timeout_o             <= 1'b0;
      cmd_err_o             <= 1'b0;
    end else begin
      connect_req_o         <= conn_ok;
      connect_addr_o        <= conn_ok ? connect_to_host_i : '0;
      disconnect_o          <= dis_ok || drop_fire;
      disconnect_host_num_o <= dis_ok ? disconnect_host_i : (drop_fire ? drop_sel : '0);
      cmd_err_o             <= conn_err || dis_err;
      timeout_o             <= |wait_exp;
      hb_valid_o            <= hb_v_nxt;
      hb_host_o             <= hb_h_nxt;
      rr_ptr                <= ptr_nxt;
      hb_pend               <= pend_nxt;

      for (int h = 0; h < NUM_HOSTS; h++) begin
        case (state[h])
          IDLE: begin
            if (conn_ok && (connect_to_host_i == HOST_W'(h))) begin
              state[h] <= WAIT_ACK;
              tmr[h]   <= '0;
            end
          end
          WAIT_ACK: begin
            if (dis_h[h]) begin
              state[h] <= IDLE;
              tmr[h]   <= '0;
            end else if (ack_h[h]) begin
              state[h]        <= CONNECTED;
              tmr[h]          <= '0;
              tx_cnt[h]       <= '0;
              session_up_o[h] <= 1'b1;
            end else if (tmr[h] == CONN_LAST) begin
              state[h] <= IDLE;
              tmr[h]   <= '0;
            end else begin
              tmr[h] <= tmr[h] + 1'b1;
            end
          end
          CONNECTED: begin
            if (leave[h]) begin
              state[h]        <= IDLE;
              tmr[h]          <= '0;
              tx_cnt[h]       <= '0;
              drop_pend[h]    <= 1'b0;
              session_up_o[h] <= 1'b0;
            end else begin
              drop_pend[h] <= drop_pend[h] || rx_exp[h];
              if (rx_hit[h])    tmr[h] <= '0;
              else if (!rx_exp[h]) tmr[h] <= tmr[h] + 1'b1;
              if (gnt_h[h])     tx_cnt[h] <= '0;
              else if (tx_cnt[h] != HB_LAST) tx_cnt[h] <= tx_cnt[h] + 1'b1;
            end
          end
          default: state[h] <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fix_session_mgr.sv
// tb/tb_fix_session_mgr.sv - randomized and directed bench for fix_session_mgr
module tb_fix_session_mgr;

  localparam int N  = 4;
  localparam int HW = 2;
  localparam int CT = 8;
  localparam int HB = 16;
  localparam int RX = 40;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          connect_i, disconnect_i, connected_i, valid_i, hb_ready_i;
  logic [HW-1:0] connect_to_host_i, disconnect_host_i, connected_host_addr_i, rx_host_i;
  logic          connect_req_o, disconnect_o, hb_valid_o, timeout_o, cmd_err_o;
  logic [HW-1:0] connect_addr_o, disconnect_host_num_o, hb_host_o;
  logic [N-1:0]  session_up_o;

  always #5 clk = ~clk;

  fix_session_mgr #(
    .NUM_HOSTS(N), .HOST_W(HW), .CONN_TIMEOUT(CT), .HB_INTERVAL(HB), .RX_TIMEOUT(RX)
  ) dut (
    .clk(clk), .rst(rst),
    .connect_i(connect_i), .connect_to_host_i(connect_to_host_i),
    .disconnect_i(disconnect_i), .disconnect_host_i(disconnect_host_i),
    .connected_i(connected_i), .connected_host_addr_i(connected_host_addr_i),
    .valid_i(valid_i), .rx_host_i(rx_host_i), .hb_ready_i(hb_ready_i),
    .connect_req_o(connect_req_o), .connect_addr_o(connect_addr_o),
    .disconnect_o(disconnect_o), .disconnect_host_num_o(disconnect_host_num_o),
    .hb_valid_o(hb_valid_o), .hb_host_o(hb_host_o), .session_up_o(session_up_o),
    .timeout_o(timeout_o), .cmd_err_o(cmd_err_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: 0=idle, 1=waiting for ack, 2=connected; counters in plain ints
  int       m_st [N];
  int       m_cnt[N];
  int       m_tx [N];
  bit       m_hbp[N];
  bit       m_drp[N];
  int       m_ptr, m_hbh;
  bit       m_hbv;
  bit       e_req, e_disc, e_to, e_err;
  int       e_addr, e_dh;
  logic [N-1:0] e_up;

  function automatic void model_reset();
    for (int h = 0; h < N; h++) begin
      m_st[h] = 0; m_cnt[h] = 0; m_tx[h] = 0; m_hbp[h] = 0; m_drp[h] = 0;
    end
    m_ptr = 0; m_hbh = 0; m_hbv = 0;
    e_req = 0; e_disc = 0; e_to = 0; e_err = 0; e_addr = 0; e_dh = 0; e_up = '0;
  endfunction

  function automatic void model_step();
    bit dis_ok, conn_ok, grant, fire, lv;
    int dsel, j;
    dis_ok  = disconnect_i && (m_st[disconnect_host_i] != 0);
    conn_ok = connect_i && (m_st[connect_to_host_i] == 0);
    grant   = m_hbv && hb_ready_i;
    e_req = conn_ok; e_addr = conn_ok ? int'(connect_to_host_i) : 0;
    e_err = (disconnect_i && !dis_ok) || (connect_i && !conn_ok);
    e_to  = 0;
    fire = 0; dsel = 0;
    if (!dis_ok)
      for (int h = 0; h < N; h++)
        if (!fire && m_st[h] == 2 && (m_drp[h] || m_cnt[h] == RX - 1)) begin
          fire = 1; dsel = h;
        end
    e_disc = dis_ok || fire;
    e_dh   = dis_ok ? int'(disconnect_host_i) : (fire ? dsel : 0);
    for (int h = 0; h < N; h++) begin
      lv = (dis_ok && int'(disconnect_host_i) == h) || (fire && dsel == h);
      if (m_st[h] == 0) begin
        if (conn_ok && int'(connect_to_host_i) == h) begin m_st[h] = 1; m_cnt[h] = 0; end
      end else if (m_st[h] == 1) begin
        if (lv) begin m_st[h] = 0; m_cnt[h] = 0; end
        else if (connected_i && int'(connected_host_addr_i) == h) begin
          m_st[h] = 2; m_cnt[h] = 0; m_tx[h] = 0;
        end else if (m_cnt[h] == CT - 1) begin m_st[h] = 0; m_cnt[h] = 0; e_to = 1; end
        else m_cnt[h]++;
      end else begin
        if (lv) begin
          m_st[h] = 0; m_cnt[h] = 0; m_tx[h] = 0; m_hbp[h] = 0; m_drp[h] = 0;
        end else begin
          if (m_cnt[h] == RX - 1) m_drp[h] = 1;
          if (valid_i && int'(rx_host_i) == h) m_cnt[h] = 0;
          else if (m_cnt[h] < RX - 1) m_cnt[h]++;
          if (grant && m_hbh == h) begin m_tx[h] = 0; m_hbp[h] = 0; end
          else if (m_tx[h] == HB - 1) m_hbp[h] = 1;
          else m_tx[h]++;
        end
      end
    end
    if (!(m_hbv && !grant && m_hbp[m_hbh])) begin
      if (grant) m_ptr = (m_hbh + 1) % N;
      m_hbv = 0; m_hbh = 0;
      for (int i = 0; i < N; i++) begin
        j = (m_ptr + i) % N;
        if (!m_hbv && m_hbp[j]) begin m_hbv = 1; m_hbh = j; end
      end
    end
    for (int h = 0; h < N; h++) e_up[h] = (m_st[h] == 2);
  endfunction

  task automatic compare_all();
    check_eq("connect_req_o", connect_req_o, e_req);
    check_eq("connect_addr_o", connect_addr_o, e_addr);
    check_eq("disconnect_o", disconnect_o, e_disc);
    check_eq("disconnect_host_num_o", disconnect_host_num_o, e_dh);
    check_eq("hb_valid_o", hb_valid_o, m_hbv);
    check_eq("hb_host_o", hb_host_o, m_hbh);
    check_eq("session_up_o", session_up_o, e_up);
    check_eq("timeout_o", timeout_o, e_to);
    check_eq("cmd_err_o", cmd_err_o, e_err);
  endtask

  task automatic set_idle();
    connect_i = 0; connect_to_host_i = '0; disconnect_i = 0; disconnect_host_i = '0;
    connected_i = 0; connected_host_addr_i = '0; valid_i = 0; rx_host_i = '0; hb_ready_i = 0;
  endtask

  task automatic step();
    model_step();
    @(posedge clk); #1;
    compare_all();
    set_idle();
  endtask

  task automatic do_reset();
    rst = 1; #1;
    check_eq("rst_outputs_zero", {connect_req_o, connect_addr_o, disconnect_o, disconnect_host_num_o,
             hb_valid_o, hb_host_o, session_up_o, timeout_o, cmd_err_o}, 0);
    model_reset();
    set_idle();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic conn(input int h);
    connect_i = 1; connect_to_host_i = HW'(h); step();
  endtask

  task automatic ack(input int h);
    connected_i = 1; connected_host_addr_i = HW'(h); step();
  endtask

  initial begin
    bit seen;
    int k;
    set_idle();
    model_reset();
    #1;
    do_reset();

    // Connect host 2, acknowledged three cycles later
    conn(2);
    check_eq("r026_req", connect_req_o, 1);
    check_eq("r026_addr", connect_addr_o, 2);
    step();
    check_eq("r026_req_one_cycle", connect_req_o, 0);
    step();
    ack(2);
    check_eq("r026_up", session_up_o, 4'b0100);

    // Connect host 1 with no acknowledge times out, then reconnect is accepted
    do_reset();
    conn(1);
    seen = 0; k = 0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      step();
      if (timeout_o) begin seen = 1; k = i; end
    end
    check_eq("r027_timeout_latency", k, 8);
    step();
    check_eq("r027_up1", session_up_o[1], 0);
    conn(1);
    check_eq("r027_reconnect_req", connect_req_o, 1);
    check_eq("r027_reconnect_err", cmd_err_o, 0);

    // Heartbeat round robin across hosts 0 and 3
    do_reset();
    conn(0); conn(3); ack(0); ack(3);
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      seen = hb_valid_o;
    end
    check_eq("r028_hb_seen", seen, 1);
    check_eq("r028_first_host", hb_host_o, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("r028_hold_host", {hb_valid_o, hb_host_o}, {1'b1, 2'd0});
    end
    hb_ready_i = 1; step();
    check_eq("r028_second_host", {hb_valid_o, hb_host_o}, {1'b1, 2'd3});
    hb_ready_i = 1; step();
    check_eq("r028_drained", hb_valid_o, 0);

    // Auto-drops of hosts 0 and 1 queue behind an app disconnect of host 2
    do_reset();
    conn(0); conn(1); ack(0); ack(1);
    for (int i = 0; i < 34; i++) step();
    conn(2);
    for (int i = 0; i < 3; i++) step();
    disconnect_i = 1; disconnect_host_i = 2; step();
    check_eq("r029_first", {disconnect_o, disconnect_host_num_o}, {1'b1, 2'd2});
    step();
    check_eq("r029_second", {disconnect_o, disconnect_host_num_o}, {1'b1, 2'd0});
    step();
    check_eq("r029_third", {disconnect_o, disconnect_host_num_o}, {1'b1, 2'd1});
    step();
    check_eq("r029_done", disconnect_o, 0);

    // Illegal commands raise cmd_err_o without changing state
    do_reset();
    conn(0); ack(0);
    conn(0);
    check_eq("r030_conn_err", cmd_err_o, 1);
    check_eq("r030_conn_noreq", connect_req_o, 0);
    check_eq("r030_conn_up", session_up_o, 4'b0001);
    disconnect_i = 1; disconnect_host_i = 3; step();
    check_eq("r030_dis_err", cmd_err_o, 1);
    check_eq("r030_dis_nopulse", disconnect_o, 0);
    check_eq("r030_dis_up", session_up_o, 4'b0001);

    // Reset in the middle of a handshake leaves nothing behind
    do_reset();
    conn(1);
    check_eq("r031_req_before", connect_req_o, 1);
    do_reset();
    for (int i = 0; i < 12; i++) begin
      step();
      check_eq("r031_no_timeout", timeout_o, 0);
    end

    // Randomized traffic against the reference model
    for (int c = 0; c < 3000; c++) begin
      int phase;
      phase = (c / 300) % 3;
      if ($urandom_range(0, 599) == 0) do_reset();
      connect_i             = ($urandom_range(0, 5) == 0);
      connect_to_host_i     = HW'($urandom_range(0, N - 1));
      disconnect_i          = ($urandom_range(0, 15) == 0);
      disconnect_host_i     = HW'($urandom_range(0, N - 1));
      connected_i           = ($urandom_range(0, 2) == 0);
      connected_host_addr_i = HW'($urandom_range(0, N - 1));
      valid_i               = (phase == 0) ? ($urandom_range(0, 1) == 0)
                            : (phase == 1) ? ($urandom_range(0, 19) == 0) : 1'b0;
      rx_host_i             = HW'($urandom_range(0, N - 1));
      hb_ready_i            = ($urandom_range(0, 2) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
